// File: rtl/proc_csr_io_if.sv
// D-stage CSR command bus between the TinyRV1 control unit and proc_csr_io.
// The read result returns on the same bus, aligned to stage X.
interface proc_csr_io_if #(
  parameter int unsigned W    = 32,
  parameter int unsigned SELW = 3
);
  logic            en_D;
  logic [SELW-1:0] csrr_sel_D;
  logic            csrw_val_D;
  logic [SELW-1:0] csrw_sel_D;
  logic [W-1:0]    csrw_data_D;
  logic            squash_X;
  logic [W-1:0]    rdata_X;

  modport master (
    output en_D, csrr_sel_D, csrw_val_D, csrw_sel_D, csrw_data_D, squash_X,
    input  rdata_X
  );

  modport slave (
    input  en_D, csrr_sel_D, csrw_val_D, csrw_sel_D, csrw_data_D, squash_X,
    output rdata_X
  );
endinterface

// File: rtl/proc_csr_io.sv
// CSR I/O unit: NUM_IN input and NUM_OUT output channels, an X/M/W write pipeline
// with squash, readback forwarding, per-channel update pulses and a cycle counter.
module proc_csr_io #(
  parameter int unsigned W       = 32,
  parameter int unsigned NUM_IN  = 3,
  parameter int unsigned NUM_OUT = 3,
  parameter int unsigned SYNC    = 0,
  parameter int unsigned SELW    = $clog2(NUM_IN + NUM_OUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_IN*W-1:0]  in_data,
  output logic [NUM_OUT*W-1:0] out_data,
  output logic [NUM_OUT-1:0]   out_upd,
  proc_csr_io_if.slave         csr
);

  localparam int unsigned     CHW     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [SELW-1:0] OUT_LO  = SELW'(NUM_IN);
  localparam logic [SELW-1:0] CNT_SEL = SELW'(NUM_IN + NUM_OUT);

  logic [NUM_IN*W-1:0] in_s;

  generate
    if (SYNC != 0) begin : g_sync
      logic [NUM_IN*W-1:0] s1_q, s1_d, s2_q, s2_d;

      always_comb begin
        s1_d = in_data;
        s2_d = s1_q;
        in_s = s2_q;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_q <= '0;
          s2_q <= '0;
        end else begin
          s1_q <= s1_d;
          s2_q <= s2_d;
        end
      end
    end else begin : g_nosync
      always_comb in_s = in_data;
    end
  endgenerate

  logic                 x_val_q, x_val_d, m_val_q, m_val_d, w_val_q, w_val_d;
  logic [CHW-1:0]       x_chan_q, x_chan_d, m_chan_q, m_chan_d, w_chan_q, w_chan_d;
  logic [W-1:0]         x_data_q, x_data_d, m_data_q, m_data_d, w_data_q, w_data_d;
  logic [W-1:0]         cnt_q, cnt_d;
  logic [W-1:0]         rdata_q, rdata_d;
  logic [NUM_OUT*W-1:0] out_data_q, out_data_d;
  logic [NUM_OUT-1:0]   out_upd_q, out_upd_d;
  logic                 wr_in_range;

  always_comb begin
    wr_in_range = (csr.csrw_sel_D >= OUT_LO) && (csr.csrw_sel_D < CNT_SEL);
    x_val_d     = csr.csrw_val_D & csr.en_D & wr_in_range;
    x_chan_d    = CHW'(csr.csrw_sel_D - OUT_LO);
    x_data_d    = csr.csrw_data_D;

    m_val_d  = x_val_q & ~csr.squash_X;
    m_chan_d = x_chan_q;
    m_data_d = x_data_q;

    w_val_d  = m_val_q;
    w_chan_d = m_chan_q;
    w_data_d = m_data_q;

    cnt_d = cnt_q + W'(1);

    out_data_d = out_data_q;
    out_upd_d  = '0;
    for (int unsigned j = 0; j < NUM_OUT; j++) begin
      if (w_val_q && (w_chan_q == CHW'(j))) begin
        out_data_d[j*W +: W] = w_data_q;
        out_upd_d[j]         = 1'b1;
      end
    end
  end

  // Readback takes the youngest in-flight write (X, then M, then W) before the register.
  always_comb begin
    rdata_d = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (csr.csrr_sel_D == SELW'(i)) rdata_d = in_s[i*W +: W];
    end
    for (int unsigned j = 0; j < NUM_OUT; j++) begin
      if (csr.csrr_sel_D == SELW'(NUM_IN + j)) begin
        if (x_val_q && (x_chan_q == CHW'(j)))      rdata_d = x_data_q;
        else if (m_val_q && (m_chan_q == CHW'(j))) rdata_d = m_data_q;
        else if (w_val_q && (w_chan_q == CHW'(j))) rdata_d = w_data_q;
        else                                       rdata_d = out_data_q[j*W +: W];
      end
    end
    if (csr.csrr_sel_D == CNT_SEL) rdata_d = cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_val_q    <= 1'b0;
      m_val_q    <= 1'b0;
      w_val_q    <= 1'b0;
      x_chan_q   <= '0;
      m_chan_q   <= '0;
      w_chan_q   <= '0;
      x_data_q   <= '0;
      m_data_q   <= '0;
      w_data_q   <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      out_data_q <= '0;
      out_upd_q  <= '0;
    end else begin
      x_val_q    <= x_val_d;
      m_val_q    <= m_val_d;
      w_val_q    <= w_val_d;
      x_chan_q   <= x_chan_d;
      m_chan_q   <= m_chan_d;
      w_chan_q   <= w_chan_d;
      x_data_q   <= x_data_d;
      m_data_q   <= m_data_d;
      w_data_q   <= w_data_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      out_data_q <= out_data_d;
      out_upd_q  <= out_upd_d;
    end
  end

  always_comb begin
    out_data    = out_data_q;
    out_upd     = out_upd_q;
    csr.rdata_X = rdata_q;
  end

endmodule

// File: tb/tb_proc_csr_io.sv
// Bench for proc_csr_io: a cycle-indexed write-history model (commit at issue+4,
// forwarding from the last three issues) checked every cycle, plus literal pins.
module tb_proc_csr_io;

  localparam int unsigned W    = 32;
  localparam int unsigned NI   = 3;
  localparam int unsigned NO   = 3;
  localparam int unsigned SELW = 3;
  localparam int          MAXC = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  logic [NI*W-1:0] in_data;
  logic [NO*W-1:0] out_data;
  logic [NO-1:0]   out_upd;

  proc_csr_io_if #(.W(W), .SELW(SELW)) bus ();

  proc_csr_io #(.W(W), .NUM_IN(NI), .NUM_OUT(NO), .SYNC(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .out_data(out_data),
    .out_upd(out_upd), .csr(bus)
  );

  // Narrow unsynchronised instance: counter wrap and same-cycle input visibility.
  logic [15:0] in2;
  logic [15:0] out2;
  logic [1:0]  upd2;

  proc_csr_io_if #(.W(8), .SELW(3)) bus2 ();

  proc_csr_io #(.W(8), .NUM_IN(2), .NUM_OUT(2), .SYNC(0)) dut2 (
    .clk(clk), .rst(rst2), .in_data(in2), .out_data(out2),
    .out_upd(upd2), .csr(bus2)
  );

  int tests = 0;
  int fails = 0;

  bit          wv_h [MAXC];
  logic [1:0]  wch_h[MAXC];
  logic [31:0] wd_h [MAXC];
  logic [95:0] in_h [MAXC];
  logic [31:0] out_m[3];
  int          cyc;
  logic [95:0] exp_out;
  logic [2:0]  exp_upd;
  logic [31:0] exp_rd;
  logic [95:0] in_cur;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    for (int j = 0; j < 3; j++) out_m[j] = '0;
    for (int c = 0; c < MAXC; c++) begin
      wv_h[c] = 1'b0;
      in_h[c] = '0;
    end
    exp_out = '0;
    exp_upd = '0;
    exp_rd  = '0;
  endtask

  // One cycle: drive D-stage inputs, check current outputs, then advance the model.
  task automatic step(input bit en, input bit wv, input logic [2:0] wsel,
                      input logic [31:0] wdat, input logic [2:0] rsel, input bit sq);
    logic [31:0] rd;
    bit          found;
    int          c;
    c = cyc;
    in_data          = in_cur;
    bus.en_D         = en;
    bus.csrw_val_D   = wv;
    bus.csrw_sel_D   = wsel;
    bus.csrw_data_D  = wdat;
    bus.csrr_sel_D   = rsel;
    bus.squash_X     = sq;
    in_h[c]          = in_cur;

    rd = '0;
    if (rsel < 3) begin
      if (c >= 2) rd = in_h[c-2][rsel*32 +: 32];
    end else if (rsel < 6) begin
      rd    = out_m[rsel-3];
      found = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        if (!found && c >= k && wv_h[c-k] && (wch_h[c-k] == 2'(rsel - 3))) begin
          rd    = wd_h[c-k];
          found = 1'b1;
        end
      end
    end else if (rsel == 6) begin
      rd = 32'(c);
    end

    if (sq && c >= 1) wv_h[c-1] = 1'b0;
    wv_h[c]  = en && wv && (wsel >= 3) && (wsel <= 5);
    wch_h[c] = 2'(wsel - 3);
    wd_h[c]  = wdat;

    @(negedge clk);
    chk("out_data", out_data, exp_out);
    chk("out_upd", out_upd, exp_upd);
    chk("rdata_X", bus.rdata_X, exp_rd);

    @(posedge clk);
    #1;
    cyc     = c + 1;
    exp_upd = '0;
    if (cyc >= 4 && wv_h[cyc-4]) begin
      out_m[wch_h[cyc-4]] = wd_h[cyc-4];
      exp_upd             = 3'b001 << wch_h[cyc-4];
    end
    exp_out = {out_m[2], out_m[1], out_m[0]};
    exp_rd  = rd;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 3'd0, 32'h0, 3'd6, 1'b0);
  endtask

  task automatic wr(input logic [2:0] sel, input logic [31:0] data);
    step(1'b1, 1'b1, sel, data, 3'd6, 1'b0);
  endtask

  task automatic rd(input logic [2:0] sel);
    step(1'b1, 1'b0, 3'd0, 32'h0, sel, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v1;
    logic [7:0]  exp2, nexp2;
    logic [2:0]  sel2;

    in_cur            = '0;
    in_data           = '0;
    bus.en_D          = 1'b0;
    bus.csrw_val_D    = 1'b0;
    bus.csrw_sel_D    = '0;
    bus.csrw_data_D   = '0;
    bus.csrr_sel_D    = '0;
    bus.squash_X      = 1'b0;
    in2               = '0;
    bus2.en_D         = 1'b0;
    bus2.csrw_val_D   = 1'b0;
    bus2.csrw_sel_D   = '0;
    bus2.csrw_data_D  = '0;
    bus2.csrr_sel_D   = '0;
    bus2.squash_X     = 1'b0;
    cyc               = 0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    chk("reset_rdata", bus.rdata_X, 32'h0);

    // Basic write to output channel 1 at cycle 10.
    while (cyc < 10) idle();
    wr(3'd4, 32'hDEADBEEF);
    while (cyc < 13) idle();
    chk("basic_upd_before", out_upd, 3'b000);
    idle();
    chk("basic_out_ch1", out_data[63:32], 32'hDEADBEEF);
    chk("basic_upd_pulse", out_upd, 3'b010);
    chk("model_basic_ch1", exp_out[63:32], 32'hDEADBEEF);
    idle();
    chk("basic_upd_after", out_upd, 3'b000);

    // Bubble, squash, then a surviving write.
    step(1'b0, 1'b1, 3'd3, 32'h11, 3'd6, 1'b0);
    wr(3'd3, 32'h22);
    step(1'b1, 1'b0, 3'd0, 32'h0, 3'd6, 1'b1);
    wr(3'd3, 32'h33);
    repeat (2) idle();
    chk("squash_no_change", out_data[31:0], 32'h0);
    idle();
    chk("squash_commit_33", out_data[31:0], 32'h33);
    chk("squash_commit_upd", out_upd, 3'b001);
    chk("model_squash_33", exp_out[31:0], 32'h33);

    // Forwarding from X, M, W, then from the register.
    for (int b = 0; b < 3; b++) begin
      wr(3'd3, 32'd5);
      wr(3'd3, 32'd6);
      repeat (b) idle();
      rd(3'd3);
      chk($sformatf("fwd_bubbles%0d", b), bus.rdata_X, 32'd6);
    end
    repeat (4) idle();
    rd(3'd3);
    chk("fwd_committed", bus.rdata_X, 32'd6);

    // Synchronised input channel 2.
    in_cur[95:64] = 32'h5A;
    repeat (3) idle();
    in_cur[95:64] = 32'hA5;
    rd(3'd2);
    chk("sync_t0_old", bus.rdata_X, 32'h5A);
    rd(3'd2);
    chk("sync_t1_old", bus.rdata_X, 32'h5A);
    rd(3'd2);
    chk("sync_t2_new", bus.rdata_X, 32'hA5);

    // Out-of-range read and dropped write.
    rd(3'd7);
    chk("sel7_zero", bus.rdata_X, 32'h0);
    wr(3'd1, 32'hFFFF);
    repeat (3) idle();
    chk("sel1_dropped", {out_upd, out_data}, {3'b000, 32'h0, 32'hDEADBEEF, 32'h6});

    // Counter reads at cycles 100 and 105.
    while (cyc < 100) idle();
    rd(3'd6);
    chk("counter_100", bus.rdata_X, 32'd100);
    v1 = bus.rdata_X;
    while (cyc < 105) idle();
    rd(3'd6);
    chk("counter_105", bus.rdata_X, 32'd105);
    chk("counter_diff", bus.rdata_X - v1, 32'd5);

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      bit          en, wv, sq;
      logic [2:0]  wsel, rsel;
      logic [31:0] wdat;
      en   = ($urandom_range(0, 3) != 0);
      wv   = 1'($urandom_range(0, 1));
      wsel = 3'($urandom_range(0, 7));
      wdat = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
      sq   = ($urandom_range(0, 4) == 0);
      rsel = 3'($urandom_range(0, 7));
      if (sq && rsel >= 3 && rsel <= 5) rsel = 3'd6;
      if ($urandom_range(0, 7) == 0) in_cur = {$urandom, $urandom, $urandom};
      step(en, wv, wsel, wdat, rsel, sq);
    end

    // Reset asserted mid-cycle with writes in X, M and W.
    wr(3'd5, 32'h77);
    repeat (4) idle();
    chk("pre_rst_ch2", out_data[95:64], 32'h77);
    wr(3'd3, 32'h1);
    wr(3'd4, 32'h2);
    wr(3'd5, 32'h3);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_out", out_data, 96'h0);
    chk("rst_async_upd", out_upd, 3'b000);
    chk("rst_async_rdata", bus.rdata_X, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    repeat (8) idle();
    chk("post_rst_no_commit", out_data, 96'h0);

    // Narrow instance: SYNC=0 input visibility and counter wrap.
    @(posedge clk);
    #1 rst2 = 1'b0;
    exp2 = '0;
    for (int k = 0; k < 300; k++) begin
      if (k >= 253 && k <= 258)  sel2 = 3'd4;
      else if (k % 4 == 0)       sel2 = 3'd0;
      else if (k % 4 == 3)       sel2 = 3'd2;
      else                       sel2 = 3'd4;
      in2              = 16'($urandom);
      bus2.csrr_sel_D  = sel2;
      @(negedge clk);
      chk("dut2_rdata", bus2.rdata_X, exp2);
      if (k == 256) chk("dut2_ctr_255", bus2.rdata_X, 8'd255);
      if (k == 257) chk("dut2_ctr_wrap", bus2.rdata_X, 8'd0);
      if (sel2 == 3'd0)      nexp2 = in2[7:0];
      else if (sel2 == 3'd4) nexp2 = 8'(k);
      else                   nexp2 = 8'h0;
      @(posedge clk);
      #1 exp2 = nexp2;
    end
    chk("dut2_outputs_idle", {upd2, out2}, 18'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
